timer_dev: RTL and testbench

- Memory-mapped countdown timer on the system bridge.
- Responds to word writes issued by the multicycle CPU controller through the bridge (`we` = `bridge_en` from the store state) and to word reads.
- Raises the interrupt request the controller samples at the end of each instruction (`intreq`).
- It is the device end of the bridge write and interrupt interface that the controller initiates and consumes.

---
 rtl/timer_dev.sv | 137 +++++++++++++
 tb/tb_timer_dev.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a CPU interrupt.
// Optional prescaler on address 3 is enabled by defining TIMER_PRESCALE_EN.
module timer_dev #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic             r_irq_flag;

  logic w_en;
  logic w_auto;
  logic w_im;
  logic w_tick;
  logic w_zero;
  logic w_expire;
  logic w_wr_ctrl;
  logic w_wr_preset;

  assign w_en        = r_ctrl[0];
  assign w_auto      = (r_ctrl[2:1] == 2'b01);
  assign w_im        = r_ctrl[3];
  assign w_zero      = (r_count == '0);
  assign w_wr_ctrl   = we && (addr == 2'd0);
  assign w_wr_preset = we && (addr == 2'd1);
  assign w_expire    = (r_state == CNT) && w_en && w_zero && w_tick;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_prescale;
  logic [7:0] r_psc_cnt;

  assign w_tick = (r_psc_cnt == r_prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_psc_cnt  <= '0;
    end else begin
      if (we && (addr == 2'd3))
        r_prescale <= din[7:0];
      if (r_state == LOAD)
        r_psc_cnt <= '0;
      else if ((r_state == CNT) && w_en)
        r_psc_cnt <= w_tick ? '0 : r_psc_cnt + 8'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_en) w_next = LOAD;
      LOAD: w_next = CNT;
      CNT: begin
        if (!w_en)
          w_next = IDLE;
        else if (w_zero && w_tick)
          w_next = INT;
      end
      INT:  w_next = w_auto ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A CTRL write on the expiry edge overrides the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl)
        r_ctrl <= din[3:0];
      else if (w_expire && !w_auto)
        r_ctrl[0] <= 1'b0;

      if (w_wr_preset)
        r_preset <= din;

      if (w_wr_ctrl || w_wr_preset)
        r_irq_flag <= 1'b0;
      else if (w_expire)
        r_irq_flag <= 1'b1;

      if (r_state == LOAD)
        r_count <= r_preset;
      else if ((r_state == CNT) && w_en && !w_zero && w_tick)
        r_count <= r_count - WIDTH'(1);
    end
  end

  assign irq = w_im && (w_auto ? (r_state == INT) : r_irq_flag);

  always_comb begin
    dout = '0;
    case (addr)
      2'd0: dout = WIDTH'(r_ctrl);
      2'd1: dout = r_preset;
      2'd2: dout = r_count;
`ifdef TIMER_PRESCALE_EN
      2'd3: dout = WIDTH'(r_prescale);
`else
      2'd3: dout = '0;
`endif
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev; prescaler checks run when TIMER_PRESCALE_EN is defined.
module tb_timer_dev;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_vec;
  int n_err;

  timer_dev #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    addr  = '0;
    we    = 1'b0;
    din   = '0;
    ticks(2);
    rst = 1'b0;

    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);
    chk_rd("rst_addr3", 2'd3, 32'd0);

    // reset in the middle of a count
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    ticks(52);
    chk_rd("mid_count50", 2'd2, 32'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_irq", {31'd0, irq}, 32'd0);
    chk_rd("mrst_count", 2'd2, 32'd0);
    chk_rd("mrst_ctrl", 2'd0, 32'd0);
    chk_rd("mrst_preset", 2'd1, 32'd0);
    ticks(3);
    chk_rd("mrst_idle_count", 2'd2, 32'd0);

    // one-shot, PRESET=3, IM=1
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    chk_rd("os_load_lat", 2'd2, 32'd0);
    tick();
    chk_rd("os_e2", 2'd2, 32'd3);
    tick();
    chk_rd("os_e3", 2'd2, 32'd2);
    tick();
    chk_rd("os_e4", 2'd2, 32'd1);
    tick();
    chk_rd("os_e5", 2'd2, 32'd0);
    chk("os_e5_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("os_e6_irq", {31'd0, irq}, 32'd1);
    chk_rd("os_e6_ctrl", 2'd0, 32'h8);
    ticks(3);
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    chk_rd("os_count_held", 2'd2, 32'd0);
    wr(2'd1, 32'd5);
    chk("os_preset_clr", {31'd0, irq}, 32'd0);
    chk_rd("os_no_midload", 2'd2, 32'd0);

    // auto-reload, PRESET=2, IM=1: period 5
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      logic [31:0] exp_cnt;
      logic        exp_irq;
      tick();
      exp_cnt = 32'd0;
      exp_irq = 1'b0;
      if (k >= 2) begin
        case ((k - 2) % 5)
          0: exp_cnt = 32'd2;
          1: exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
        exp_irq = ((k - 2) % 5 == 3);
      end
      chk($sformatf("ar_irq_k%0d", k), {31'd0, irq}, {31'd0, exp_irq});
      chk_rd($sformatf("ar_cnt_k%0d", k), 2'd2, exp_cnt);
    end
    chk_rd("ar_ctrl_en", 2'd0, 32'hB);
    wr(2'd0, 32'h0);
    ticks(6);

    // one-shot with IM=0
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("im0_irq_k%0d", k), {31'd0, irq}, 32'd0);
    end
    chk_rd("im0_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("im0_unmask", {31'd0, irq}, 32'd0);
    ticks(2);
    chk("im0_unmask_hold", {31'd0, irq}, 32'd0);

    // stop mid-count, then restart from new PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    ticks(7);
    chk_rd("stop_pre", 2'd2, 32'd5);
    wr(2'd0, 32'h0);
    chk_rd("stop_at4", 2'd2, 32'd4);
    ticks(3);
    chk_rd("stop_hold4", 2'd2, 32'd4);
    wr(2'd1, 32'd7);
    chk_rd("stop_preset_nl", 2'd2, 32'd4);
    wr(2'd0, 32'h1);
    tick();
    chk_rd("restart_load", 2'd2, 32'd4);
    tick();
    chk_rd("restart_7", 2'd2, 32'd7);
    tick();
    chk_rd("restart_6", 2'd2, 32'd6);
    wr(2'd0, 32'h1);
    chk_rd("en_rewrite_nr", 2'd2, 32'd5);
    wr(2'd0, 32'h0);
    ticks(2);

    // CTRL write on the expiry edge wins
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    ticks(3);
    chk_rd("race_cnt0", 2'd2, 32'd0);
    chk("race_pre_irq", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h9);
    chk("race_irq_clr", {31'd0, irq}, 32'd0);
    chk_rd("race_ctrl", 2'd0, 32'h9);
    ticks(3);
    chk_rd("race_reload", 2'd2, 32'd1);
    ticks(2);
    chk("race_irq2", {31'd0, irq}, 32'd1);
    chk_rd("race_ctrl2", 2'd0, 32'h8);
    ticks(2);

`ifdef TIMER_PRESCALE_EN
    wr(2'd3, 32'h1);
    chk_rd("psc_rd", 2'd3, 32'h1);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    ticks(2);
    chk_rd("psc_l", 2'd2, 32'd2);
    tick();
    chk_rd("psc_l1", 2'd2, 32'd2);
    tick();
    chk_rd("psc_l2", 2'd2, 32'd1);
    tick();
    chk_rd("psc_l3", 2'd2, 32'd1);
    tick();
    chk_rd("psc_l4", 2'd2, 32'd0);
    tick();
    chk("psc_l5_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("psc_l6_irq", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h0);
`else
    wr(2'd3, 32'h55);
    chk_rd("addr3_ro", 2'd3, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
